m6502_wb_bridge: RTL and testbench

Bus bridge sitting directly downstream of the wrapped 6502 core. It converts each CPU byte access (address, write data, write-enable) into a single Wishbone classic cycle toward the user-area bus, and stalls the CPU via RDY until the access completes. It returns read data on the CPU data-in bus and aborts hung accesses with a timeout. This lets the core run against on-chip Wishbone peripherals and memory instead of raw GPIO.

---
 rtl/m6502_wb_bridge.sv | 137 +++++++++++++
 tb/tb_m6502_wb_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/m6502_wb_bridge.sv
// m6502_wb_bridge: turns each 6502 byte access into one Wishbone classic
// cycle, stalls the CPU with cpu_rdy while the cycle is open, returns the
// addressed read byte on cpu_di and aborts hung cycles after TIMEOUT cycles.
module m6502_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        err_o,
  input  logic        err_clr_i
);

  typedef enum logic {IDLE, BUS} state_t;

  // Counter value in the last BUS cycle a slave is allowed before abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic [1:0]  lane, lane_next;
  logic        cyc_q, cyc_next;
  logic        rdy_next;
  logic        we_next;
  logic [3:0]  sel_next;
  logic [31:0] adr_next;
  logic [31:0] dat_next;
  logic [7:0]  di_next;
  logic        err_next;
  logic        err_set;
  logic [7:0]  rd_byte;

  // Cycle and strobe are one register so they can never disagree.
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;

  // Pick the byte lane the captured CPU address points at.
  always_comb begin
    rd_byte = wbm_dat_i[7:0];
    case (lane)
      2'd0: rd_byte = wbm_dat_i[7:0];
      2'd1: rd_byte = wbm_dat_i[15:8];
      2'd2: rd_byte = wbm_dat_i[23:16];
      2'd3: rd_byte = wbm_dat_i[31:24];
      default: rd_byte = wbm_dat_i[7:0];
    endcase
  end

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lane_next  = lane;
    cyc_next   = cyc_q;
    rdy_next   = cpu_rdy;
    we_next    = wbm_we_o;
    sel_next   = wbm_sel_o;
    adr_next   = wbm_adr_o;
    dat_next   = wbm_dat_o;
    di_next    = cpu_di;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        state_next = BUS;
        cnt_next   = 8'd0;
        lane_next  = cpu_ab[1:0];
        cyc_next   = 1'b1;
        rdy_next   = 1'b0;
        we_next    = cpu_we;
        sel_next   = 4'b0001 << cpu_ab[1:0];
        adr_next   = BASE_ADDR + {16'b0, cpu_ab[15:2], 2'b00};
        dat_next   = {4{cpu_do}};
      end
      BUS: begin
        if (wbm_ack_i) begin
          state_next = IDLE;
          cyc_next   = 1'b0;
          rdy_next   = 1'b1;
          if (!wbm_we_o) di_next = rd_byte;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cyc_next   = 1'b0;
          rdy_next   = 1'b1;
          err_set    = 1'b1;
          if (!wbm_we_o) di_next = 8'hFF;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    err_next = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_o);
  end

  // State and all outputs are registered; reset drops any pending access.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      lane      <= 2'd0;
      cyc_q     <= 1'b0;
      cpu_rdy   <= 1'b1;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'd0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      cpu_di    <= 8'h00;
      err_o     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      lane      <= lane_next;
      cyc_q     <= cyc_next;
      cpu_rdy   <= rdy_next;
      wbm_we_o  <= we_next;
      wbm_sel_o <= sel_next;
      wbm_adr_o <= adr_next;
      wbm_dat_o <= dat_next;
      cpu_di    <= di_next;
      err_o     <= err_next;
    end
  end

endmodule

// File: tb/tb_m6502_wb_bridge.sv
// tb_m6502_wb_bridge: directed and randomised accesses through the 6502
// Wishbone bridge with a bench-driven slave and hand-computed expectations.
module tb_m6502_wb_bridge;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        err_o;
  logic        err_clr_i;

  int compared;
  int mismatched;

  m6502_wb_bridge #(
    .BASE_ADDR(32'h3000_0000),
    .TIMEOUT  (15)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cpu_ab   (cpu_ab),
    .cpu_do   (cpu_do),
    .cpu_we   (cpu_we),
    .cpu_di   (cpu_di),
    .cpu_rdy  (cpu_rdy),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .err_o    (err_o),
    .err_clr_i(err_clr_i)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge while the bridge is in IDLE. Presents one CPU
  // access, checks the captured bus cycle, acks it after 'waits' BUS cycles
  // (never if waits is large) and returns the number of BUS cycles seen.
  task automatic applyStimulus(input logic [15:0] ab, input logic [7:0] dout,
                               input logic we, input int waits,
                               input logic [31:0] rdata, input logic clr,
                               input logic [31:0] exp_adr,
                               input logic [3:0] exp_sel, output int bus_cycles);
    cpu_ab    = ab;
    cpu_do    = dout;
    cpu_we    = we;
    err_clr_i = clr;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    err_clr_i = 1'b0;
    checkOutput("bus_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    checkOutput("bus_stb", {31'b0, wbm_stb_o}, 32'd1);
    checkOutput("bus_rdy", {31'b0, cpu_rdy}, 32'd0);
    checkOutput("bus_adr", wbm_adr_o, exp_adr);
    checkOutput("bus_sel", {28'b0, wbm_sel_o}, {28'b0, exp_sel});
    checkOutput("bus_we", {31'b0, wbm_we_o}, {31'b0, we});
    checkOutput("bus_dat", wbm_dat_o, {4{dout}});
    if (clr) checkOutput("err_clr", {31'b0, err_o}, 32'd0);
    bus_cycles = 0;
    while (wbm_cyc_o === 1'b1 && bus_cycles < 64) begin
      wbm_ack_i = (bus_cycles == waits);
      wbm_dat_i = rdata;
      bus_cycles++;
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
    end
    wbm_ack_i = 1'b0;
    checkOutput("done_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    checkOutput("done_rdy", {31'b0, cpu_rdy}, 32'd1);
  endtask

  initial begin
    int          n;
    logic [7:0]  exp_di;
    logic [15:0] ab;
    logic [7:0]  dout;
    logic        we;
    int          waits;
    logic [31:0] rdata;

    compared   = 0;
    mismatched = 0;
    wb_rst_i   = 1'b1;
    cpu_ab     = 16'h0;
    cpu_do     = 8'h0;
    cpu_we     = 1'b0;
    wbm_dat_i  = 32'h0;
    wbm_ack_i  = 1'b0;
    err_clr_i  = 1'b0;

    // Reset values
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("rst_rdy", {31'b0, cpu_rdy}, 32'd1);
    checkOutput("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    checkOutput("rst_di", {24'b0, cpu_di}, 32'h00);
    checkOutput("rst_adr", wbm_adr_o, 32'h0);
    checkOutput("rst_sel", {28'b0, wbm_sel_o}, 32'h0);
    checkOutput("rst_dat", wbm_dat_o, 32'h0);
    checkOutput("rst_err", {31'b0, err_o}, 32'd0);

    // Zero-wait read, lane 2
    wb_rst_i = 1'b0;
    applyStimulus(16'h1236, 8'h00, 1'b0, 0, 32'hAABB_CCDD, 1'b0,
                  32'h3000_1234, 4'b0100, n);
    checkOutput("zw_cycles", n, 32'd1);
    checkOutput("zw_di", {24'b0, cpu_di}, 32'hBB);

    // Write with three wait states
    applyStimulus(16'hFFFF, 8'h5A, 1'b1, 3, 32'hDEAD_BEEF, 1'b0,
                  32'h3000_FFFC, 4'b1000, n);
    checkOutput("wr_cycles", n, 32'd4);
    checkOutput("wr_di", {24'b0, cpu_di}, 32'hBB);
    checkOutput("wr_err", {31'b0, err_o}, 32'd0);

    // Read with no ack: timeout
    applyStimulus(16'h0010, 8'h00, 1'b0, 255, 32'h0, 1'b0,
                  32'h3000_0010, 4'b0001, n);
    checkOutput("to_cycles", n, 32'd15);
    checkOutput("to_di", {24'b0, cpu_di}, 32'hFF);
    checkOutput("to_err", {31'b0, err_o}, 32'd1);

    // Ack in the 15th BUS cycle wins; err cleared at this capture
    applyStimulus(16'h0020, 8'h00, 1'b0, 14, 32'h0000_0011, 1'b1,
                  32'h3000_0020, 4'b0001, n);
    checkOutput("co_cycles", n, 32'd15);
    checkOutput("co_di", {24'b0, cpu_di}, 32'h11);
    checkOutput("co_err", {31'b0, err_o}, 32'd0);

    // Reset in the 2nd BUS cycle of a stalled read
    cpu_ab = 16'h0040;
    cpu_we = 1'b0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("mr_cyc1", {31'b0, wbm_cyc_o}, 32'd1);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("mr_cyc2", {31'b0, wbm_cyc_o}, 32'd1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("mr_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    checkOutput("mr_rdy", {31'b0, cpu_rdy}, 32'd1);
    checkOutput("mr_di", {24'b0, cpu_di}, 32'h00);
    cpu_ab = 16'h0104;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("mr_hold_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    wb_rst_i = 1'b0;
    applyStimulus(16'h0104, 8'h00, 1'b0, 0, 32'h1234_5678, 1'b0,
                  32'h3000_0104, 4'b0001, n);
    checkOutput("mr_post_cycles", n, 32'd1);
    checkOutput("mr_post_di", {24'b0, cpu_di}, 32'h78);

    // Back-to-back random accesses with 0..5 wait states
    exp_di = 8'h78;
    for (int i = 0; i < 100; i++) begin
      ab    = 16'($urandom);
      dout  = 8'($urandom);
      we    = 1'($urandom_range(0, 1));
      waits = int'($urandom_range(0, 5));
      rdata = $urandom;
      applyStimulus(ab, dout, we, waits, rdata, 1'b0,
                    32'h3000_0000 + {16'b0, ab[15:2], 2'b00},
                    4'b0001 << ab[1:0], n);
      if (!we) exp_di = 8'(rdata >> (8 * ab[1:0]));
      checkOutput("rnd_cycles", n, waits + 1);
      checkOutput("rnd_di", {24'b0, cpu_di}, {24'b0, exp_di});
    end
    checkOutput("rnd_err", {31'b0, err_o}, 32'd0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
